// File: rtl/dac_gain_pkg.sv
// dac_gain_pkg: shared defaults, saturation limits and clamp helper for the
// DAC gain scaler.
package dac_gain_pkg;

   localparam int unsigned DATA_W_DEF = 14;
   localparam int unsigned GAIN_W_DEF = 8;

   // Output limits for the default sample width
   localparam int SAT_MAX = (1 <<< (DATA_W_DEF - 1)) - 1;
   localparam int SAT_MIN = -(1 <<< (DATA_W_DEF - 1));

   // Clamp a wide signed value into [lo, hi]
   function automatic logic signed [63:0] saturate(
      input logic signed [63:0] v,
      input logic signed [63:0] lo,
      input logic signed [63:0] hi
   );
      logic signed [63:0] r;
      r = v;
      if (v > hi) begin
         r = hi;
      end else if (v < lo) begin
         r = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/dac_gain_ramp.sv
// dac_gain_ramp: owns the gain used by the multiplier. Gain updates happen
// only on accepted samples. With DAC_GAIN_SCALER_RAMP_EN defined the gain
// walks one step per RAMP_DIV samples toward the target; otherwise it loads
// the target directly and ramp_busy is tied low.
module dac_gain_ramp
   import dac_gain_pkg::*;
#(
   parameter int unsigned GAIN_W   = GAIN_W_DEF,
   parameter int unsigned RAMP_DIV = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [GAIN_W-1:0] gain_in,
   input  logic              s_valid,
   output logic [GAIN_W-1:0] gain_applied,
   output logic              ramp_busy
);

   // A zero divider has no meaningful ramp rate
   if (RAMP_DIV < 1) begin : g_bad_ramp_div
      $error("dac_gain_ramp: RAMP_DIV must be at least 1");
   end

`ifdef DAC_GAIN_SCALER_RAMP_EN
   localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

   logic [CNT_W-1:0] ramp_cnt;

   // Stepped ramp; the counter survives a re-target and idles at zero once on target
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gain_applied <= GAIN_W'(1);
         ramp_cnt     <= '0;
         ramp_busy    <= 1'b0;
      end else begin
         ramp_busy <= (gain_applied != gain_in);
         if (gain_applied == gain_in) begin
            ramp_cnt <= '0;
         end else if (s_valid) begin
            if (ramp_cnt == CNT_LAST) begin
               ramp_cnt     <= '0;
               gain_applied <= (gain_applied < gain_in) ? gain_applied + GAIN_W'(1)
                                                        : gain_applied - GAIN_W'(1);
            end else begin
               ramp_cnt <= ramp_cnt + CNT_W'(1);
            end
         end
      end
   end
`else
   // Direct load of the target on each accepted sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gain_applied <= GAIN_W'(1);
      end else if (s_valid) begin
         gain_applied <= gain_in;
      end
   end

   assign ramp_busy = 1'b0;
`endif

endmodule

// File: rtl/dac_gain_scaler.sv
// dac_gain_scaler: two-stage signed sample scaler feeding the DAC driver.
// Stage 1 multiplies by the applied gain, stage 2 floors by GAIN_FRAC and
// saturates. Optional gain ramp selected by DAC_GAIN_SCALER_RAMP_EN.
module dac_gain_scaler
   import dac_gain_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned GAIN_W    = GAIN_W_DEF,
   parameter int unsigned GAIN_FRAC = 0,
   parameter int unsigned RAMP_DIV  = 256
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [GAIN_W-1:0]        gain_in,
   input  logic                     s_valid,
   input  logic signed [DATA_W-1:0] s_data,
   output logic                     m_valid,
   output logic signed [DATA_W-1:0] m_data,
   output logic [GAIN_W-1:0]        gain_applied,
   output logic                     ramp_busy,
   output logic                     sat_flag,
   input  logic                     sat_clr
);

   localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
   localparam logic signed [63:0] SAT_HI = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
   localparam logic signed [63:0] SAT_LO = -(64'sd1 <<< (DATA_W - 1));

   logic signed [PROD_W-1:0] prod_c;
   logic signed [PROD_W-1:0] s1_prod;
   logic                     s1_valid;
   logic signed [63:0]       shifted_c;
   logic signed [63:0]       clipped_c;
   logic                     clamped_c;

   dac_gain_ramp #(
      .GAIN_W   (GAIN_W),
      .RAMP_DIV (RAMP_DIV)
   ) u_ramp (
      .clk          (clk),
      .reset_n      (reset_n),
      .gain_in      (gain_in),
      .s_valid      (s_valid),
      .gain_applied (gain_applied),
      .ramp_busy    (ramp_busy)
   );

   // Gain is zero-extended so it always acts as a non-negative multiplier
   assign prod_c = PROD_W'(s_data) * PROD_W'($signed({1'b0, gain_applied}));

   // Stage 1: product and strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_prod  <= '0;
      end else begin
         s1_valid <= s_valid;
         if (s_valid) begin
            s1_prod <= prod_c;
         end
      end
   end

   // Arithmetic shift floors toward minus infinity, then clamp
   assign shifted_c = 64'(s1_prod) >>> GAIN_FRAC;
   assign clipped_c = saturate(shifted_c, SAT_LO, SAT_HI);
   assign clamped_c = (clipped_c != shifted_c);

   // Stage 2: output register; m_data holds while idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else begin
         m_valid <= s1_valid;
         if (s1_valid) begin
            m_data <= DATA_W'(clipped_c);
         end
      end
   end

   // Sticky saturation flag; a new clamp beats a simultaneous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sat_flag <= 1'b0;
      end else if (s1_valid && clamped_c) begin
         sat_flag <= 1'b1;
      end else if (sat_clr) begin
         sat_flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dac_gain_scaler.sv
// tb_dac_gain_scaler: directed vectors for dac_gain_scaler. Instance a runs
// with GAIN_FRAC=0 / RAMP_DIV=4, instance b with GAIN_FRAC=4 / RAMP_DIV=1.
// Ramp or step vectors are chosen by DAC_GAIN_SCALER_RAMP_EN.
module tb_dac_gain_scaler;
   import dac_gain_pkg::*;

   logic clk;
   logic reset_n;

   logic              s_valid_a, s_valid_b;
   logic signed [13:0] s_data_a, s_data_b;
   logic [7:0]        gain_in_a, gain_in_b;
   logic              sat_clr_a, sat_clr_b;
   logic              m_valid_a, m_valid_b;
   logic signed [13:0] m_data_a, m_data_b;
   logic [7:0]        gain_applied_a, gain_applied_b;
   logic              ramp_busy_a, ramp_busy_b;
   logic              sat_flag_a, sat_flag_b;

   int checks = 0;
   int errors = 0;

   dac_gain_scaler #(.DATA_W(14), .GAIN_W(8), .GAIN_FRAC(0), .RAMP_DIV(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .gain_in(gain_in_a), .s_valid(s_valid_a),
      .s_data(s_data_a), .m_valid(m_valid_a), .m_data(m_data_a),
      .gain_applied(gain_applied_a), .ramp_busy(ramp_busy_a),
      .sat_flag(sat_flag_a), .sat_clr(sat_clr_a)
   );

   dac_gain_scaler #(.DATA_W(14), .GAIN_W(8), .GAIN_FRAC(4), .RAMP_DIV(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .gain_in(gain_in_b), .s_valid(s_valid_b),
      .s_data(s_data_b), .m_valid(m_valid_b), .m_data(m_data_b),
      .gain_applied(gain_applied_b), .ramp_busy(ramp_busy_b),
      .sat_flag(sat_flag_b), .sat_clr(sat_clr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input bit b, input logic signed [13:0] d);
      if (b) begin
         s_valid_b = 1'b1;
         s_data_b  = d;
      end else begin
         s_valid_a = 1'b1;
         s_data_a  = d;
      end
      tick();
      s_valid_a = 1'b0;
      s_valid_b = 1'b0;
   endtask

   // One isolated sample, checked two cycles later
   task automatic xfer(input bit b, input logic signed [13:0] d,
                       input logic signed [31:0] exp, input string tag);
      pulse(b, d);
      tick();
      chk({tag, "_v"}, b ? m_valid_b : m_valid_a, 1);
      chk(tag, b ? m_data_b : m_data_a, exp);
   endtask

   // Feed zero samples until the applied gain reaches the target (bounded)
   task automatic settle(input bit b, input string tag);
      int n = 0;
      while (n < 600 && (b ? (gain_applied_b != gain_in_b)
                           : (gain_applied_a != gain_in_a))) begin
         pulse(b, 14'sd0);
         n++;
      end
      tick();
      tick();
      chk(tag, b ? gain_applied_b : gain_applied_a, b ? gain_in_b : gain_in_a);
   endtask

   initial begin
      logic signed [13:0] got[16];
      logic signed [31:0] exp_s[16];
      int nsamp;
      int k;

      reset_n   = 1'b0;
      s_valid_a = 1'b0; s_valid_b = 1'b0;
      s_data_a  = '0;   s_data_b  = '0;
      gain_in_a = 8'd1; gain_in_b = 8'd1;
      sat_clr_a = 1'b0; sat_clr_b = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_m_valid", m_valid_a, 0);
      chk("rst_m_data", m_data_a, 0);
      chk("rst_gain", gain_applied_a, 1);
      chk("rst_sat", sat_flag_a, 0);
      chk("rst_busy", ramp_busy_a, 0);
      reset_n = 1'b1;
      tick();

      // Unity passthrough, back-to-back
      s_valid_a = 1'b1; s_data_a = 14'sd1234;
      tick();
      chk("uni_lat", m_valid_a, 0);
      s_data_a = -14'sd4321;
      tick();
      s_valid_a = 1'b0;
      chk("uni0_v", m_valid_a, 1);
      chk("uni0", m_data_a, 1234);
      tick();
      chk("uni1_v", m_valid_a, 1);
      chk("uni1", m_data_a, -4321);
      tick();
      chk("uni_idle_v", m_valid_a, 0);
      chk("uni_hold", m_data_a, -4321);
      chk("uni_sat", sat_flag_a, 0);

      // Positive clamp, then clear
      gain_in_a = 8'd3;
      settle(1'b0, "settle_g3");
      chk("pre_pos_sat", sat_flag_a, 0);
      xfer(1'b0, 14'sd4000, SAT_MAX, "pos_clamp");
      chk("pos_sat", sat_flag_a, 1);
      sat_clr_a = 1'b1;
      tick();
      sat_clr_a = 1'b0;
      chk("pos_clr", sat_flag_a, 0);

      // Gain 2: exact limits do not clamp, then negative clamp vs sat_clr
      gain_in_a = 8'd2;
      settle(1'b0, "settle_g2");
      xfer(1'b0, 14'sd4095, 8190, "g2_hi");
      xfer(1'b0, -14'sd4096, -8192, "g2_lo_edge");
      chk("g2_nosat", sat_flag_a, 0);
      s_valid_a = 1'b1; s_data_a = -14'sd5000;
      tick();
      s_valid_a = 1'b0;
      sat_clr_a = 1'b1;
      tick();
      sat_clr_a = 1'b0;
      chk("neg_clamp", m_data_a, SAT_MIN);
      chk("set_wins", sat_flag_a, 1);
      tick();
      sat_clr_a = 1'b1;
      tick();
      sat_clr_a = 1'b0;
      chk("neg_clr", sat_flag_a, 0);

      // Gain 0 yields zero and never saturates
      gain_in_a = 8'd0;
      settle(1'b0, "settle_g0");
      xfer(1'b0, -14'sd8192, 0, "g0_zero");
      chk("g0_nosat", sat_flag_a, 0);

      // Gain change: ramp or direct step
      gain_in_a = 8'd1;
      settle(1'b0, "settle_g1");
`ifdef DAC_GAIN_SCALER_RAMP_EN
      nsamp = 13;
      for (int i = 0; i < 13; i++) exp_s[i] = 100 * (i / 4 + 1);
      gain_in_a = 8'd4;
      tick();
      chk("busy_rise", ramp_busy_a, 1);
`else
      nsamp = 2;
      exp_s[0] = 100;
      exp_s[1] = 500;
      gain_in_a = 8'd5;
      tick();
      chk("busy_off", ramp_busy_a, 0);
`endif
      k = 0;
      for (int j = 0; j < nsamp + 3; j++) begin
         s_valid_a = (j < nsamp);
         s_data_a  = 14'sd100;
         tick();
         if (m_valid_a && k < 16) begin
            got[k] = m_data_a;
            k++;
         end
`ifdef DAC_GAIN_SCALER_RAMP_EN
         if (j == 11) chk("busy_s12", ramp_busy_a, 1);
         if (j == 12) chk("busy_fall", ramp_busy_a, 0);
`endif
      end
      s_valid_a = 1'b0;
      chk("chg_count", k, nsamp);
      for (int i = 0; i < nsamp && i < k; i++) begin
         chk($sformatf("chg_s%0d", i), got[i], exp_s[i]);
      end
`ifdef DAC_GAIN_SCALER_RAMP_EN
      chk("chg_gain", gain_applied_a, 4);
`else
      chk("chg_gain", gain_applied_a, 5);
`endif

      // Fractional gain on instance b: floor toward minus infinity
      gain_in_b = 8'd32;
      settle(1'b1, "settle_b32");
      xfer(1'b1, -14'sd3, -6, "b32_neg");
      xfer(1'b1, 14'sd5, 10, "b32_pos");
      gain_in_b = 8'd33;
      settle(1'b1, "settle_b33");
      xfer(1'b1, -14'sd3, -7, "b33_floor");
      xfer(1'b1, 14'sd3, 6, "b33_pos");
      gain_in_b = 8'd32;
      settle(1'b1, "settle_b32b");

      // Reset with two samples in flight
      s_valid_b = 1'b1; s_data_b = -14'sd3;
      tick();
      tick();
      s_valid_b = 1'b0;
      chk("rst_pre_v", m_valid_b, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_v", m_valid_b, 0);
      chk("rst_mid_d", m_data_b, 0);
      chk("rst_mid_g", gain_applied_b, 1);
      chk("rst_mid_sat", sat_flag_b, 0);
      tick();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rst_quiet%0d", i), m_valid_b, 0);
      end
      s_valid_b = 1'b1; s_data_b = -14'sd3;
      tick();
      s_valid_b = 1'b0;
      chk("post_lat", m_valid_b, 0);
      tick();
      chk("post_v", m_valid_b, 1);
      chk("post_d", m_data_b, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dac_gain_scaler.md
# dac_gain_scaler

Sample-path stage directly downstream of the Avalon-MM DAC gain register. Takes the register's 8-bit gain word and the signed DAC sample stream, and applies the gain at sample boundaries, optionally ramping one step at a time to avoid zipper noise. Multiplies, floors, saturates and presents the scaled sample to the DAC driver. It also keeps a sticky saturation flag for software.

## Interface
Parameters:
- DATA_W, 14: signed sample width, in and out.
- GAIN_W, 8: unsigned gain width; matches the gain register's out_port.
- GAIN_FRAC, 0: fractional bits of the gain; unity = 2^GAIN_FRAC.
- RAMP_DIV, 256: accepted samples per ramp step; must be at least 1.

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk, in, 1: system clock; same domain as the gain register.
- reset_n, in, 1: asynchronous active-low reset.
- gain_in, in, GAIN_W: target gain, quasi-static, from the gain register.
- s_valid, in, 1: input sample strobe; no backpressure.
- s_data, in, DATA_W: signed input sample.
- m_valid, out, 1: output sample strobe.
- m_data, out, DATA_W: signed scaled, saturated sample.
- gain_applied, out, GAIN_W: gain currently used by the multiplier.
- ramp_busy, out, 1: high while gain_applied differs from gain_in.
- sat_flag, out, 1: sticky; set when any output was clamped.
- sat_clr, in, 1: single-cycle clear of sat_flag.

## Operation
- Reset values: gain_applied = 1, which matches the gain register's reset value. m_valid = 0, m_data = 0, sat_flag = 0, ramp_busy = 0, ramp counter = 0.
- Gain changes take effect only on cycles with s_valid = 1. The sample in that cycle uses the old gain, and the new gain applies from the next sample.
- Ramp, with the macro defined:
  - On each s_valid cycle where gain_applied differs from gain_in, the ramp counter increments.
  - When the counter reaches RAMP_DIV-1, gain_applied moves one step toward gain_in (+1 or -1) and the counter clears.
  - Whenever gain_applied equals gain_in, the counter is held at 0.
  - If gain_in changes mid-ramp, the ramp re-targets without clearing the counter.
- Stage 1: the product s_data × {0, gain_applied} is computed as a signed DATA_W+GAIN_W+1-bit value and registered together with s_valid.
- Stage 2:
  - Arithmetic right shift by GAIN_FRAC, rounding toward minus infinity.
  - Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. The default limits are -8192 and 8191.
  - Register the result into m_data and m_valid.
- m_data holds its last value while m_valid = 0.
- Gain 0 produces m_data = 0. Gain 0 never saturates.
- sat_flag is set on any stage-2 valid sample that was clamped. sat_clr clears it. If set and clear occur in the same cycle, set wins.

## Timing
- Latency: s_valid in cycle n gives m_valid in cycle n+2.
- Throughput: one sample per cycle; back-to-back s_valid is supported.
- ramp_busy is a registered compare: it reflects the gain_applied/gain_in mismatch one cycle after either changes.
- Reset mid-stream: in-flight samples are discarded, and all outputs return to their reset values within the assertion cycle. The first post-reset output appears 2 cycles after the first post-reset s_valid.
- Full-scale ramp from 1 to 255: 254 × RAMP_DIV samples.

## Configuration
- DAC_GAIN_SCALER_RAMP_EN defined: stepped ramp as described above.
- Macro undefined:
  - gain_applied takes gain_in directly on any s_valid cycle.
  - No ramp counter is built.
  - ramp_busy is tied to 0.
  - Latency and saturation behaviour are unchanged.

## Structure
- Package dac_gain_pkg: DATA_W/GAIN_W defaults, the saturation limit constants SAT_MAX/SAT_MIN, and a saturate function.
- Sub-module dac_gain_ramp: holds gain_applied, the ramp counter and ramp_busy, including the macro-dependent logic.
- The top level holds the two pipeline stages and sat_flag.

## Test plan
- Unity passthrough: gain_in = 1, GAIN_FRAC = 0, input 1234 then -4321 back-to-back -> m_data 1234, -4321 at +2 cycles; sat_flag = 0.
- Positive clamp: gain_in = 3, input 4000 -> m_data 8191, sat_flag = 1.
- Negative clamp and sat_clr priority: gain_in = 2, input -5000 -> m_data -8192. A sat_clr pulse in the same cycle as the clamp leaves sat_flag = 1; a later sat_clr with no clamp clears it.
- Ramp (macro on, RAMP_DIV = 4): gain_in steps from 1 to 4 with input constant 100.
  - Outputs 100 ×4, 200 ×4, 300 ×4, then 400.
  - ramp_busy falls after the 12th sample.
- Step (macro off): gain_in changes from 1 to 5 between samples 100 and 100 -> outputs 100, 500.
- Reset mid-stream (GAIN_FRAC = 4, gain 32, input -3 gives floor -6): assert reset_n with two samples in flight -> no m_valid until 2 cycles after the next s_valid; gain_applied = 1, m_data = 0.
